io_line_responder: RTL
======================

# io_line_responder

Half-duplex responder for a single shared bidirectional line, the far end of an inout pin driven by an initiator. It listens on the line for an initiator frame, decodes it into a parallel word, then, after a fixed turnaround gap, drives a one-word reply back on the same line. It is the only block in the design that decides when the line is driven, so no other logic drives the inout.

## Interface
Parameters:
- WIDTH, 8, data bits per frame.
- BIT_CYCLES, 4, CLK cycles per bit on the line; must be even and ≥2.
- TURN_CYCLES, 2, idle cycles with the line released between receive stop bit and transmit start bit; ≥1.

Ports:
- CLK  input  1  clock. One clock domain.
- RESET  input  1  reset. Synchronous and active-high.
- IO  inout  1  shared line; idle level 1 from an external pull-up; driven only while io_oe=1.
- io_oe  output  1  high while the block drives IO; exposed for the bench.
- rx_data  output  WIDTH  last good received word; held until the next good frame.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- rx_err  output  1  one-cycle pulse: framing error (stop bit sampled 0).
- tx_data  input  WIDTH  reply word.
- tx_valid  input  1  reply offered.
- tx_ready  output  1  one-entry reply buffer empty; transfer on tx_valid & tx_ready.
- busy  output  1  state ≠ IDLE.

## Operation
- Frame format, both directions: start bit 0, then WIDTH data bits LSB first, then stop bit 1.
- The receive path passes IO through a 2-flop synchronizer; all receive decisions use the synchronized value.
- Output driver: IO = io_oe ? tx_bit : Z.
- States: IDLE, RX_START, RX_DATA, RX_STOP, TURN, TX_START, TX_DATA, TX_STOP.
- IDLE: synchronized line 1→0 -> RX_START.
- RX_START: after BIT_CYCLES/2 cycles, sample the line.
  - 0 -> RX_DATA.
  - 1 -> IDLE (glitch). No pulse.
- RX_DATA: sample every BIT_CYCLES into the shift register, LSB first; after WIDTH samples -> RX_STOP.
- RX_STOP: sample after BIT_CYCLES.
  - 1: load rx_data, pulse rx_valid -> TURN.
  - 0: pulse rx_err, rx_data unchanged -> IDLE. No reply is sent; the buffer is retained.
- TURN: line released for TURN_CYCLES.
  - Buffer full at the end of TURN -> TX_START.
  - Buffer empty -> IDLE (no reply).
- TX_START, TX_DATA, TX_STOP: io_oe=1. Each bit is held exactly BIT_CYCLES. After the stop bit, io_oe=0, the buffer is cleared (tx_ready=1), state -> IDLE.
- Reply buffer:
  - Accepts in any state while empty.
  - A word accepted during TURN is sent in that turnaround.
  - Once TX_START is entered, buffer contents are frozen.
- Line activity in TURN and TX states is ignored. No receive during transmit.

## Timing
- Reset values: io_oe=0 (IO released), rx_data=0, rx_valid=0, rx_err=0, tx_ready=1, busy=0, state IDLE. The buffer and the shift register are cleared.
- Let C be the first cycle the synchronized line reads 0.
  - Start sample at C+BIT_CYCLES/2.
  - Data bit k sampled at C+BIT_CYCLES/2+(k+1)·BIT_CYCLES.
  - Stop bit sampled at C+BIT_CYCLES/2+(WIDTH+1)·BIT_CYCLES.
- rx_valid/rx_err: asserted the cycle after the stop sample, for exactly one cycle. TURN begins in that cycle.
- io_oe rises the cycle after the last TURN cycle. It stays high for exactly (WIDTH+2)·BIT_CYCLES cycles. tx_ready rises in the cycle io_oe falls.
- RESET asserted mid-frame (any state): on that edge io_oe=0, the buffer is dropped, and no pulse is emitted. The frame is not resumed.
- tx_valid while tx_ready=0: ignored, no overwrite.

## Structure
- Shared package io_line_pkg:
  - state enum.
  - Frame-length constant function (WIDTH+2).
  - Default parameter constants.
- Sub-module io_bit_timer: down-counter loaded with BIT_CYCLES/2, BIT_CYCLES or TURN_CYCLES. It emits a one-cycle expiry tick. The FSM and the shift registers live in io_line_responder.

## Test plan
All scenarios use WIDTH=8, BIT_CYCLES=4, TURN_CYCLES=2. The bench models the initiator with a pull-up.
- Reset: hold RESET 3 cycles -> io_oe=0, IO=Z, rx_valid=0, rx_err=0, tx_ready=1, busy=0.
- Receive: initiator sends 0xA5, no reply loaded -> a single rx_valid pulse with rx_data=0xA5, rx_err=0. The line is never driven. busy falls 2 cycles after rx_valid.
- Reply: load 0x3C, then the initiator sends 0x11 -> rx_data=0x11. io_oe rises 2 cycles after rx_valid. IO carries 0,0,0,1,1,1,1,0,0,1, 4 cycles each (40 cycles). Then io_oe=0 and tx_ready=1.
- Glitch: line low 1 cycle in IDLE -> no rx_valid, no rx_err; busy returns to 0 within 3 cycles.
- Framing error: frame 0x5A with stop bit 0, buffer loaded with 0x77 -> a single rx_err pulse, rx_data unchanged, no io_oe. tx_ready stays 0. The next good frame gets reply 0x77.
- Reset mid-transmit: assert RESET at bit 4 of a reply -> io_oe=0 on that edge, tx_ready=1. No rx_valid or rx_err afterwards.

Source files
------------

// File: rtl/io_line_pkg.sv
// Shared definitions for the half-duplex line responder.
//   state_e     : responder FSM states
//   frame_bits  : bits on the line per frame (start + data + stop)
//   DEF_*       : default parameter values
package io_line_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_BIT_CYCLES  = 4;
  localparam int DEF_TURN_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_START,
    S_RX_DATA,
    S_RX_STOP,
    S_TURN,
    S_TX_START,
    S_TX_DATA,
    S_TX_STOP
  } state_e;

  function automatic int frame_bits(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/io_line_responder_if.sv
// Parallel-side bundle of the line responder.
//   rx_data/rx_valid/rx_err : received word and one-cycle status pulses
//   tx_data/tx_valid/tx_ready : reply word handshake into a one-entry buffer
// slave  : responder side
// master : user side
interface io_line_responder_if
  import io_line_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_err;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport slave  (output rx_data, rx_valid, rx_err, tx_ready,
                  input  tx_data, tx_valid);
  modport master (input  rx_data, rx_valid, rx_err, tx_ready,
                  output tx_data, tx_valid);
endinterface

// File: rtl/io_bit_timer.sv
// Down-counter used for bit, half-bit and turnaround timing.
//   clk, rst : clock, synchronous active-high reset
//   load_i   : (re)start with length len_i
//   len_i    : period in cycles (>= 1)
//   tick_o   : one-cycle pulse in the len_i-th cycle after the load edge
module io_bit_timer #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] len_i,
  output logic          tick_o
);
  logic [TW-1:0] cnt_q;
  logic          act_q;

  // Loaded with len-1 so the tick lands on the last cycle of the period;
  // a load in the tick cycle restarts seamlessly for back-to-back bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      act_q <= 1'b0;
    end else if (load_i) begin
      cnt_q <= len_i - TW'(1);
      act_q <= 1'b1;
    end else if (act_q) begin
      if (cnt_q == '0) act_q <= 1'b0;
      else             cnt_q <= cnt_q - TW'(1);
    end
  end

  assign tick_o = act_q && (cnt_q == '0);
endmodule

// File: rtl/io_line_responder.sv
// Half-duplex responder on one shared bidirectional line.
// Receives a frame (start 0, WIDTH data bits LSB first, stop 1), presents
// the word, then after TURN_CYCLES with the line released replies with the
// buffered word in the same frame format.
//   CLK, RESET : clock, synchronous active-high reset
//   IO         : shared line (external pull-up), driven only while io_oe
//   io_oe      : high while this block drives IO
//   busy       : FSM not idle
//   bus        : rx word/pulses and tx reply handshake
module io_line_responder
  import io_line_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int BIT_CYCLES  = DEF_BIT_CYCLES,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic                CLK,
  input  logic                RESET,
  inout  wire                 IO,
  output logic                io_oe,
  output logic                busy,
  io_line_responder_if.slave  bus
);
  localparam int MAXL = (BIT_CYCLES > TURN_CYCLES) ? BIT_CYCLES : TURN_CYCLES;
  localparam int TW   = $clog2(MAXL + 1);
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] L_HALF = TW'(BIT_CYCLES / 2);
  localparam logic [TW-1:0] L_BIT  = TW'(BIT_CYCLES);
  localparam logic [TW-1:0] L_TURN = TW'(TURN_CYCLES);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] rsr_q, rsr_d;
  logic [WIDTH-1:0] tsr_q, tsr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_err_q, rx_err_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             full_q, full_d;
  logic             accept;
  logic             tmr_load;
  logic [TW-1:0]    tmr_len;
  logic             tick;
  logic             tx_bit;

  io_bit_timer #(.TW(TW)) u_tmr (
    .clk    (CLK),
    .rst    (RESET),
    .load_i (tmr_load),
    .len_i  (tmr_len),
    .tick_o (tick)
  );

  // Line synchronizer; prev_q gives the falling-edge detect in IDLE.
  // Reset to the idle level so a released line does not look like a start.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= IO;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      rsr_q      <= '0;
      tsr_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      buf_q      <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      rsr_q      <= rsr_d;
      tsr_q      <= tsr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    rsr_d      = rsr_q;
    tsr_d      = tsr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    buf_d      = buf_q;
    full_d     = full_q;
    tmr_load   = 1'b0;
    tmr_len    = L_BIT;

    // Buffer takes a word in any state while empty; once full it holds
    // until the reply stop bit completes.
    accept = bus.tx_valid && !full_q;
    if (accept) begin
      buf_d  = bus.tx_data;
      full_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d  = S_RX_START;
          tmr_load = 1'b1;
          tmr_len  = L_HALF;
        end
      end
      S_RX_START: begin
        if (tick) begin
          if (!sync2_q) begin
            state_d  = S_RX_DATA;
            bitcnt_d = '0;
            tmr_load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RX_DATA: begin
        if (tick) begin
          rsr_d    = WIDTH'({sync2_q, rsr_q} >> 1);
          tmr_load = 1'b1;
          if (bitcnt_q == LAST) state_d  = S_RX_STOP;
          else                  bitcnt_d = bitcnt_q + CW'(1);
        end
      end
      S_RX_STOP: begin
        if (tick) begin
          if (sync2_q) begin
            rx_data_d  = rsr_q;
            rx_valid_d = 1'b1;
            state_d    = S_TURN;
            tmr_load   = 1'b1;
            tmr_len    = L_TURN;
          end else begin
            rx_err_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_TURN: begin
        // A word arriving in the last turnaround cycle still makes it.
        if (tick) begin
          if (full_d) begin
            state_d  = S_TX_START;
            tsr_d    = buf_d;
            tmr_load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_TX_START: begin
        if (tick) begin
          state_d  = S_TX_DATA;
          bitcnt_d = '0;
          tmr_load = 1'b1;
        end
      end
      S_TX_DATA: begin
        if (tick) begin
          tsr_d    = tsr_q >> 1;
          tmr_load = 1'b1;
          if (bitcnt_q == LAST) state_d  = S_TX_STOP;
          else                  bitcnt_d = bitcnt_q + CW'(1);
        end
      end
      S_TX_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          full_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    io_oe  = 1'b0;
    tx_bit = 1'b1;
    unique case (state_q)
      S_TX_START: begin io_oe = 1'b1; tx_bit = 1'b0;     end
      S_TX_DATA:  begin io_oe = 1'b1; tx_bit = tsr_q[0]; end
      S_TX_STOP:  begin io_oe = 1'b1; tx_bit = 1'b1;     end
      default:    ;
    endcase
  end

  assign IO           = io_oe ? tx_bit : 1'bz;
  assign busy         = (state_q != S_IDLE);
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_err   = rx_err_q;
  assign bus.tx_ready = !full_q;
endmodule
